// File: rtl/camera_frame_tracker.sv
// Tags camera pixels with (hcount, vcount), pulses frame start/done, checks row/frame geometry.
// Pixel latency 1 cycle; no backpressure, so the consumer must take every valid_out beat.
module camera_frame_tracker #(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) (
  input  logic                    clk_pixel_in,
  input  logic                    rst_in,
  input  logic                    hs_cam_in,
  input  logic                    vs_cam_in,
  input  logic [15:0]             data_in,
  input  logic                    valid_in,
  input  logic                    err_clear_in,
  output logic [15:0]             pixel_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic [VCOUNT_WIDTH-1:0] vcount_out,
  output logic                    valid_out,
  output logic                    frame_start_out,
  output logic                    frame_done_out,
  output logic [HCOUNT_WIDTH-1:0] row_len_out,
  output logic [VCOUNT_WIDTH-1:0] row_count_out,
  output logic                    row_err_out,
  output logic                    frame_err_out
);

  localparam logic [HCOUNT_WIDTH-1:0] H_LIM = HCOUNT_WIDTH'(H_ACTIVE);
  localparam logic [VCOUNT_WIDTH-1:0] V_LIM = VCOUNT_WIDTH'(V_ACTIVE);

  typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

  state_t                  state, state_nxt;
  logic                    hs_prev, vs_prev;
  logic [HCOUNT_WIDTH-1:0] hcount;
  logic [VCOUNT_WIDTH-1:0] vcount;
  logic                    row_open;

  logic                    hs_fall, vs_fall, vs_rise;
  logic                    in_frame, pix, in_range, accept, open_eff;
  logic                    row_close, frame_close, row_set, frame_set;
  logic [HCOUNT_WIDTH-1:0] hcount_inc, len_now;
  logic [VCOUNT_WIDTH-1:0] vcount_inc, rows_now;

  always_comb begin
    hs_fall     = hs_prev & ~hs_cam_in;
    vs_fall     = vs_prev & ~vs_cam_in;
    vs_rise     = ~vs_prev & vs_cam_in;
    in_frame    = (state == FRAME);
    pix         = in_frame & valid_in;
    in_range    = (hcount < H_LIM) && (vcount < V_LIM);
    accept      = pix & in_range;
    hcount_inc  = (&hcount) ? hcount : hcount + HCOUNT_WIDTH'(1);
    vcount_inc  = (&vcount) ? vcount : vcount + VCOUNT_WIDTH'(1);
    // A pixel arriving on the closing edge still belongs to the row being closed.
    len_now     = pix ? hcount_inc : hcount;
    open_eff    = row_open | pix;
    row_close   = in_frame & open_eff & (hs_fall | vs_fall);
    frame_close = in_frame & vs_fall;
    rows_now    = row_close ? vcount_inc : vcount;
    row_set     = row_close && (len_now != H_LIM);
    frame_set   = (pix & ~in_range) | (frame_close && (rows_now != V_LIM));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (!vs_cam_in) state_nxt = IDLE;
      IDLE:    if (vs_rise)    state_nxt = FRAME;
      FRAME:   if (vs_fall)    state_nxt = IDLE;
      default:                 state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) state <= SYNC;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      hs_prev         <= 1'b0;
      vs_prev         <= 1'b0;
      hcount          <= '0;
      vcount          <= '0;
      row_open        <= 1'b0;
      pixel_out       <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      valid_out       <= 1'b0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      row_len_out     <= '0;
      row_count_out   <= '0;
      row_err_out     <= 1'b0;
      frame_err_out   <= 1'b0;
    end else begin
      hs_prev         <= hs_cam_in;
      vs_prev         <= vs_cam_in;
      valid_out       <= accept;
      frame_start_out <= accept && (hcount == '0) && (vcount == '0);
      frame_done_out  <= frame_close;

      if (accept) begin
        pixel_out  <= data_in;
        hcount_out <= hcount;
        vcount_out <= vcount;
      end

      if ((state == IDLE) && vs_rise) begin
        hcount   <= '0;
        vcount   <= '0;
        row_open <= 1'b0;
      end else if (in_frame) begin
        if (row_close) begin
          hcount      <= '0;
          vcount      <= vcount_inc;
          row_open    <= 1'b0;
          row_len_out <= len_now;
        end else begin
          hcount   <= len_now;
          row_open <= open_eff;
        end
      end

      if (frame_close) row_count_out <= rows_now;

      // Error sets win over a coincident clear.
      if (row_set)           row_err_out <= 1'b1;
      else if (err_clear_in) row_err_out <= 1'b0;

      if (frame_set)         frame_err_out <= 1'b1;
      else if (err_clear_in) frame_err_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_camera_frame_tracker.sv
// Scoreboard bench for camera_frame_tracker: frames described as row lengths, expected
// pixels/frame results queued at stimulus time and popped by an independent monitor.
module tb_camera_frame_tracker;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HW = 11;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          hs, vs, valid, err_clear;
  logic [15:0]   data;
  logic [15:0]   pixel_out;
  logic [HW-1:0] hcount_out, row_len_out;
  logic [VW-1:0] vcount_out, row_count_out;
  logic          valid_out, frame_start_out, frame_done_out, row_err_out, frame_err_out;

  camera_frame_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) dut (
    .clk_pixel_in(clk), .rst_in(rst), .hs_cam_in(hs), .vs_cam_in(vs),
    .data_in(data), .valid_in(valid), .err_clear_in(err_clear),
    .pixel_out(pixel_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .valid_out(valid_out), .frame_start_out(frame_start_out), .frame_done_out(frame_done_out),
    .row_len_out(row_len_out), .row_count_out(row_count_out),
    .row_err_out(row_err_out), .frame_err_out(frame_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          h;
    int          v;
    bit          s;
  } pix_t;

  typedef struct {
    int rows;
    int last_len;
    bit rerr;
    bit ferr;
  } frm_t;

  pix_t exp_pix[$];
  frm_t exp_frm[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_rerr = 0;
  bit   m_ferr = 0;
  int   lens[4];
  bit   coin[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT output event against the head of the scoreboard queues.
  initial begin
    pix_t p;
    frm_t f;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        if (exp_pix.size() == 0) chk("unexpected_valid_out", 1, 0);
        else begin
          p = exp_pix.pop_front();
          chk("pixel_out", pixel_out, p.d);
          chk("hcount_out", hcount_out, p.h);
          chk("vcount_out", vcount_out, p.v);
          chk("frame_start_out", frame_start_out, p.s);
        end
      end else if (frame_start_out) chk("frame_start_without_valid", 1, 0);
      if (frame_done_out) begin
        if (exp_frm.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          f = exp_frm.pop_front();
          chk("row_count_out", row_count_out, f.rows);
          chk("row_len_out", row_len_out, f.last_len);
          chk("row_err_out", row_err_out, f.rerr);
          chk("frame_err_out", frame_err_out, f.ferr);
        end
      end
    end
  end

  task automatic drive(input bit h, input bit v, input bit val, input logic [15:0] d);
    hs = h; vs = v; valid = val; data = d; err_clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    hs = 0; vs = 0; valid = 0; err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    m_rerr = 0;
    m_ferr = 0;
    chk("row_err_after_clear", row_err_out, 0);
    chk("frame_err_after_clear", frame_err_out, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {pixel_out, hcount_out, vcount_out, valid_out, frame_start_out, frame_done_out,
               row_len_out, row_count_out, row_err_out, frame_err_out}, 0);
  endtask

  // Reference: a row of n pixels yields columns 0..n-1; only columns < H on rows < V appear.
  task automatic run_frame(input int nrows, input bit open_last, input bit rise_pix, input bit gaps);
    frm_t        f;
    pix_t        p;
    logic [15:0] d;
    bit          is_open;
    for (int r = 0; r < nrows; r++) begin
      if (lens[r] != H) m_rerr = 1;
      if (lens[r] > H || r >= V) m_ferr = 1;
    end
    if (nrows != V) m_ferr = 1;
    f.rows = nrows; f.last_len = lens[nrows-1]; f.rerr = m_rerr; f.ferr = m_ferr;
    exp_frm.push_back(f);

    drive(0, 1, rise_pix, 16'($urandom));
    drive(0, 1, 0, 16'h0);
    for (int r = 0; r < nrows; r++) begin
      is_open = open_last && (r == nrows - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive(1, 1, 0, 16'h0);
        drive(0, 1, 0, 16'h0);
      end
      for (int c = 0; c < lens[r]; c++) begin
        if (gaps && $urandom_range(0, 2) == 0) drive(1, 1, 0, 16'h0);
        d = 16'($urandom);
        if (c < H && r < V) begin
          p.d = d; p.h = c; p.v = r; p.s = (c == 0 && r == 0);
          exp_pix.push_back(p);
        end
        if (c == lens[r] - 1 && coin[r]) begin
          if (is_open) drive(1, 0, 1, d);
          else begin
            if (c == 0) drive(1, 1, 0, 16'h0);
            drive(0, 1, 1, d);
          end
        end else drive(1, 1, 1, d);
      end
      if (is_open) begin
        if (!coin[r]) drive(1, 0, 0, 16'h0);
      end else begin
        if (!coin[r]) drive(0, 1, 0, 16'h0);
        drive(0, 1, 0, 16'h0);
      end
    end
    if (!open_last) drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);
  endtask

  initial begin
    int nr;
    rst = 1; hs = 0; vs = 1; valid = 0; data = 0; err_clear = 0;
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst = 0;

    // Partial frame right after reset: SYNC must swallow it.
    drive(1, 1, 1, 16'h1111);
    drive(1, 1, 1, 16'h2222);
    drive(0, 1, 0, 16'h0);
    drive(1, 1, 1, 16'h3333);
    drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);
    chk("sync_no_done_rowcount", row_count_out, 0);

    // Clean 4x2 frame.
    lens = '{4, 4, 0, 0}; coin = '{0, 0, 0, 0};
    run_frame(2, 0, 0, 0);
    chk("clean_row_count", row_count_out, 2);
    chk("clean_row_err", row_err_out, 0);
    chk("clean_frame_err", frame_err_out, 0);

    // Over-long row: fifth pixel clipped.
    lens = '{5, 4, 0, 0}; coin = '{0, 0, 0, 0};
    run_frame(2, 0, 0, 0);
    chk("long_row_err", row_err_out, 1);
    chk("long_frame_err", frame_err_out, 1);
    clear_err();

    // Last pixel of each row coincident with the hs fall.
    lens = '{4, 4, 0, 0}; coin = '{1, 1, 0, 0};
    run_frame(2, 0, 0, 0);
    chk("coin_row_len", row_len_out, 4);
    chk("coin_row_err", row_err_out, 0);

    // Three rows, vs falls with the third still open.
    lens = '{4, 4, 4, 0}; coin = '{0, 0, 0, 0};
    run_frame(3, 1, 0, 0);
    chk("open_row_count", row_count_out, 3);
    chk("open_frame_err", frame_err_out, 1);
    clear_err();

    // Randomized frames.
    for (int i = 0; i < 30; i++) begin
      nr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 2;
      for (int r = 0; r < 4; r++) begin
        lens[r] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : H;
        coin[r] = $urandom_range(0, 1);
      end
      run_frame(nr, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      if ($urandom_range(0, 2) == 0) clear_err();
    end

    // Reset in the middle of a row.
    drive(0, 1, 0, 16'h0);
    drive(0, 1, 0, 16'h0);
    exp_pix.push_back('{16'hABCD, 0, 0, 1});
    drive(1, 1, 1, 16'hABCD);
    exp_pix.push_back('{16'h1234, 1, 0, 0});
    drive(1, 1, 1, 16'h1234);
    #6;
    rst = 1;
    #1;
    check_all_zero("async_reset_outputs");
    m_rerr = 0;
    m_ferr = 0;
    @(posedge clk);
    #1;
    rst = 0;
    drive(1, 1, 1, 16'h5555);
    drive(1, 1, 1, 16'h6666);
    drive(0, 1, 0, 16'h0);
    drive(1, 1, 1, 16'h7777);
    drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);
    chk("post_reset_no_done", row_count_out, 0);

    lens = '{4, 4, 0, 0}; coin = '{0, 1, 0, 0};
    run_frame(2, 0, 1, 0);
    chk("recover_row_count", row_count_out, 2);

    repeat (4) drive(0, 0, 0, 16'h0);
    chk("pix_queue_drained", exp_pix.size(), 0);
    chk("frame_queue_drained", exp_frm.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
